// File: rtl/pcie_rx_merge_pkg.sv
// Shared constants for the PCIE receive merge block: default widths,
// lane indices and the 3-bit control FSM state encoding.
package pcie_rx_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 2;

  localparam int NUM_LANES = 2;
  localparam int LANE_D0   = 0;
  localparam int LANE_D1   = 1;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  typedef enum logic [2:0] {
    S_RESET  = ST_RESET,
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } state_t;

endpackage

// File: rtl/pcie_rx_merge_if.sv
// Stream bundle for pcie_rx_merge: two inbound lanes, the merged output
// with its pop request, and the per-lane pause returned to the link.
interface pcie_rx_merge_if import pcie_rx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              valid_in0;
  logic [DATA_W-1:0] data_in0;
  logic              valid_in1;
  logic [DATA_W-1:0] data_in1;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              src_out;
  logic              pause0;
  logic              pause1;

  // link / consumer side
  modport master (
    output valid_in0, data_in0, valid_in1, data_in1, pop,
    input  data_out, valid_out, src_out, pause0, pause1
  );

  // merge block side
  modport slave (
    input  valid_in0, data_in0, valid_in1, data_in1, pop,
    output data_out, valid_out, src_out, pause0, pause1
  );
endinterface

// File: rtl/pcie_rx_merge_rx_lane_fifo.sv
// One receive lane: small circular FIFO with occupancy count, overflow
// detection (push on full without a same-cycle pop drops the word) and a
// registered pause output with set/clear hysteresis thresholds.
module rx_lane_fifo import pcie_rx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic [ADDR_W:0]   thr_full,
  input  logic [ADDR_W:0]   thr_empty,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              overflow,
  output logic              pause
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count;
  logic              full, pop_ok, push_ok;

  assign empty    = (count == '0);
  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign pop_ok   = pop & ~empty;
  // a full lane still accepts a word when its head leaves in the same cycle
  assign push_ok  = push & (~full | pop_ok);
  assign overflow = push & full & ~pop_ok;
  assign head     = mem[rptr];

  // storage write; no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // pointers, occupancy and pause hysteresis
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      pause <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop_ok)  rptr <= rptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // set wins when the thresholds overlap
      if (count >= thr_full)       pause <= 1'b1;
      else if (count <= thr_empty) pause <= 1'b0;
    end
  end

endmodule

// File: rtl/pcie_rx_merge.sv
// PCIE receive merge: buffers lanes D0/D1 in per-lane FIFOs, merges them
// round-robin into one registered output stream on pop, returns per-lane
// pause, and tracks RESET/INIT/IDLE/ACTIVE/ERROR status.
// Optional: define RX_DROP_CNT_EN to add an 8-bit saturating drop_count.
module pcie_rx_merge import pcie_rx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [ADDR_W:0] umbral_full,
  input  logic [ADDR_W:0] umbral_empty,
  pcie_rx_merge_if.slave  bus,
  output logic            idle,
  output logic            active,
  output logic            error
`ifdef RX_DROP_CNT_EN
  ,
  output logic [7:0]      drop_count
`endif
);

  logic [NUM_LANES-1:0]             push, pop_l, empty, ovf, pause;
  logic [NUM_LANES-1:0][DATA_W-1:0] din, head;
  logic [ADDR_W:0]                  thr_full, thr_empty;
  logic                             serve, sel, last;
  logic [DATA_W-1:0]                data_q;
  logic                             src_q, vld_q;
  state_t                           state;

  assign push[LANE_D0] = bus.valid_in0;
  assign push[LANE_D1] = bus.valid_in1;
  assign din[LANE_D0]  = bus.data_in0;
  assign din[LANE_D1]  = bus.data_in1;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rx_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .din      (din[i]),
      .pop      (pop_l[i]),
      .thr_full (thr_full),
      .thr_empty(thr_empty),
      .head     (head[i]),
      .empty    (empty[i]),
      .overflow (ovf[i]),
      .pause    (pause[i])
    );
  end

  // round-robin pick: a lone non-empty lane wins, contention alternates
  always_comb begin
    serve = 1'b0;
    sel   = 1'b0;
    if (bus.pop) begin
      case (~empty)
        2'b01:   begin serve = 1'b1; sel = 1'b0;  end
        2'b10:   begin serve = 1'b1; sel = 1'b1;  end
        2'b11:   begin serve = 1'b1; sel = ~last; end
        default: begin serve = 1'b0; sel = 1'b0;  end
      endcase
    end
  end

  assign pop_l[LANE_D0] = serve & ~sel;
  assign pop_l[LANE_D1] = serve & sel;

  // registered output word; data/src hold when nothing is served
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      src_q  <= 1'b0;
      vld_q  <= 1'b0;
      last   <= 1'b1;  // so lane 0 wins the first contention
    end else begin
      vld_q <= serve;
      if (serve) begin
        data_q <= head[sel];
        src_q  <= sel;
        last   <= sel;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.src_out   = src_q;
  assign bus.valid_out = vld_q;
  assign bus.pause0    = pause[LANE_D0];
  assign bus.pause1    = pause[LANE_D1];

  // thresholds track the inputs only while in INIT
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_full  <= (ADDR_W+1)'(DEPTH);
      thr_empty <= '0;
    end else if (state == S_INIT) begin
      thr_full  <= umbral_full;
      thr_empty <= umbral_empty;
    end
  end

  // control FSM: overflow beats init; ERROR is left only through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
    end else if (state == S_RESET) begin
      state <= S_INIT;
    end else if (|ovf) begin
      state <= S_ERROR;
    end else begin
      case (state)
        S_INIT:   if (!init) state <= S_IDLE;
        S_IDLE:   if (init) state <= S_INIT;
                  else if (|push) state <= S_ACTIVE;
        S_ACTIVE: if (init) state <= S_INIT;
                  else if (&empty && !(|push)) state <= S_IDLE;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_RESET;
      endcase
    end
  end

  assign idle   = (state == S_IDLE);
  assign active = (state == S_ACTIVE);
  assign error  = (state == S_ERROR);

`ifdef RX_DROP_CNT_EN
  logic [1:0] n_ovf;
  logic [8:0] drop_sum;
  assign n_ovf    = 2'(ovf[LANE_D0]) + 2'(ovf[LANE_D1]);
  assign drop_sum = 9'(drop_count) + 9'(n_ovf);

  // saturating count of dropped words
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else if (n_ovf != 2'd0) drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_pcie_rx_merge.sv
// Directed bench for pcie_rx_merge with an output scoreboard: expected
// words are queued as stimulus is applied and checked as they emerge.
module tb_pcie_rx_merge;

  localparam int DW = 6;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [2:0] umbral_full, umbral_empty;
  logic       idle, active, error;
`ifdef RX_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q[$];   // {src, data}

  pcie_rx_merge_if #(.DATA_W(DW)) bus ();

  pcie_rx_merge dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_full (umbral_full),
    .umbral_empty(umbral_empty),
    .bus         (bus),
    .idle        (idle),
    .active      (active),
    .error       (error)
`ifdef RX_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later, score any output word
  task automatic tick();
    logic [DW:0] e;
    @(posedge clk);
    #1;
    if (bus.valid_out === 1'b1) begin
      chk("out_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 16'(bus.data_out), 16'(e[DW-1:0]));
        chk("out_src", 16'(bus.src_out), 16'(e[DW]));
      end
    end
  endtask

  task automatic reset_init();
    reset = 1'b1; init = 1'b0;
    tick();
    reset = 1'b0; init = 1'b1;
    tick();
    tick();
    init = 1'b0;
    tick();
    chk("init_idle", 16'(idle), 16'd1);
  endtask

  task automatic push0(input logic [DW-1:0] d);
    bus.valid_in0 = 1'b1; bus.data_in0 = d;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    bus.valid_in1 = 1'b1; bus.data_in1 = d;
  endtask

  task automatic nopush();
    bus.valid_in0 = 1'b0; bus.valid_in1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0;
    umbral_full = 3'd4; umbral_empty = 3'd0;
    bus.valid_in0 = 1'b0; bus.data_in0 = '0;
    bus.valid_in1 = 1'b0; bus.data_in1 = '0;
    bus.pop = 1'b0;

    // reset values
    tick();
    chk("rst_valid", 16'(bus.valid_out), 16'd0);
    chk("rst_data", 16'(bus.data_out), 16'd0);
    chk("rst_src", 16'(bus.src_out), 16'd0);
    chk("rst_pause", 16'({bus.pause1, bus.pause0}), 16'd0);
    chk("rst_status", 16'({idle, active, error}), 16'd0);
`ifdef RX_DROP_CNT_EN
    chk("rst_drop", 16'(drop_count), 16'd0);
`endif

    // RESET -> INIT -> INIT -> IDLE
    reset = 1'b0; init = 1'b1;
    tick();
    chk("st_init1", 16'({idle, active, error}), 16'd0);
    tick();
    chk("st_init2", 16'({idle, active, error}), 16'd0);
    init = 1'b0;
    tick();
    chk("st_idle", 16'({idle, active, error}), 16'b100);

    // single word on D0, two-edge latency
    push0(6'h05);
    tick();
    chk("single_active", 16'(active), 16'd1);
    chk("single_noout", 16'(bus.valid_out), 16'd0);
    nopush();
    bus.pop = 1'b1;
    exp_q.push_back({1'b0, 6'h05});
    tick();
    chk("single_valid", 16'(bus.valid_out), 16'd1);
    tick();
    chk("single_drained", 16'(bus.valid_out), 16'd0);
    chk("single_idle", 16'(idle), 16'd1);
    bus.pop = 1'b0;

    // round-robin merge of two full-ish lanes
    reset_init();
    push0(6'h01); push1(6'h21);
    tick();
    push0(6'h02); push1(6'h22);
    tick();
    nopush();
    bus.pop = 1'b1;
    exp_q.push_back({1'b0, 6'h01});
    exp_q.push_back({1'b1, 6'h21});
    exp_q.push_back({1'b0, 6'h02});
    exp_q.push_back({1'b1, 6'h22});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_valid", 16'(bus.valid_out), 16'd1);
    end
    tick();
    chk("rr_valid_drop", 16'(bus.valid_out), 16'd0);
    chk("rr_hold_data", 16'(bus.data_out), 16'h22);
    bus.pop = 1'b0;

    // pause hysteresis on D1: full=3, empty=1
    umbral_full = 3'd3; umbral_empty = 3'd1;
    reset_init();
    push1(6'h31); tick();
    push1(6'h32); tick();
    push1(6'h33); tick();
    nopush();
    chk("pause_lag", 16'(bus.pause1), 16'd0);
    tick();
    chk("pause_set", 16'(bus.pause1), 16'd1);
    bus.pop = 1'b1; exp_q.push_back({1'b1, 6'h31});
    tick();
    bus.pop = 1'b0;
    tick();
    chk("pause_hold_cnt2", 16'(bus.pause1), 16'd1);
    bus.pop = 1'b1; exp_q.push_back({1'b1, 6'h32});
    tick();
    bus.pop = 1'b0;
    chk("pause_still_cnt2", 16'(bus.pause1), 16'd1);
    tick();
    chk("pause_clear_cnt1", 16'(bus.pause1), 16'd0);
    chk("pause0_quiet", 16'(bus.pause0), 16'd0);
    bus.pop = 1'b1; exp_q.push_back({1'b1, 6'h33});
    tick();
    bus.pop = 1'b0;
    tick();

    // overflow on D0: fifth word dropped, error sticky
    umbral_full = 3'd4; umbral_empty = 3'd0;
    reset_init();
    for (int i = 0; i < 4; i++) begin
      push0(6'(8'h11 + i));
      tick();
    end
    chk("ovf_pre_err", 16'(error), 16'd0);
    push0(6'h15);
    tick();
    nopush();
    chk("ovf_err", 16'(error), 16'd1);
`ifdef RX_DROP_CNT_EN
    chk("ovf_drop", 16'(drop_count), 16'd1);
`endif
    tick();
    chk("ovf_sticky", 16'(error), 16'd1);
    bus.pop = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 6'(8'h11 + i)});
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("ovf_no5th", 16'(bus.valid_out), 16'd0);
    chk("ovf_sticky2", 16'(error), 16'd1);
    bus.pop = 1'b0;

    // push + pop on a full lane is accepted, not an overflow
    reset_init();
    for (int i = 0; i < 4; i++) begin
      push0(6'(8'h01 + i));
      tick();
    end
    push0(6'h0A);
    bus.pop = 1'b1;
    exp_q.push_back({1'b0, 6'h01});
    tick();
    nopush();
    bus.pop = 1'b0;
    chk("pp_no_err", 16'(error), 16'd0);
    tick();
    chk("pp_full_pause", 16'(bus.pause0), 16'd1);
`ifdef RX_DROP_CNT_EN
    chk("pp_drop", 16'(drop_count), 16'd0);
`endif
    bus.pop = 1'b1;
    exp_q.push_back({1'b0, 6'h02});
    exp_q.push_back({1'b0, 6'h03});
    exp_q.push_back({1'b0, 6'h04});
    exp_q.push_back({1'b0, 6'h0A});
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("pp_drained", 16'(bus.valid_out), 16'd0);
    bus.pop = 1'b0;

    // reset mid-operation discards buffered words
    push1(6'h2A);
    tick();
    nopush();
    reset_init();
    bus.pop = 1'b1;
    tick();
    chk("midrst_empty", 16'(bus.valid_out), 16'd0);
    bus.pop = 1'b0;

    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
